systolic_array_driver: RTL and testbench
========================================

Name: systolic_array_driver

Overview:
- Computes an 8x8 output tile Out = A x B from operands held in a word-addressed external memory.
- A is 8 rows by K columns, with K = dim_col_A; B is K rows by N columns, with N = dim_col_B.
- Each k-step fetches column k of A and row k of B through a 4-word-wide read port, then updates a grid of 64 MAC cells (outer-product accumulate).
- Sits between the matrix-op controller, which drives start, bases and dims, and the operand memory.

Parameters:
- DATA_WIDTH, 32, element width; two's-complement integers.
- ADDR_WIDTH, 12, word address width.
- DIM_WIDTH, 6, width of the dimension inputs.
- READ_BW, 4, words returned per memory read.
- ARR, 8, array size (Out is ARR x ARR).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse that begins an operation.
- base_A  in  ADDR_WIDTH  word address of A[0][0].
- base_B  in  ADDR_WIDTH  word address of B[0][0].
- dim_col_A  in  DIM_WIDTH  K, the column count of A (row-major stride of A).
- dim_col_B  in  DIM_WIDTH  N, the column count of B (row-major stride of B).
- read  out  1  memory read request.
- read_addr  out  ADDR_WIDTH  word address of the request.
- readdata  in  READ_BW x DATA_WIDTH  memory data; readdata[w] = mem[read_addr+w], valid the cycle after read=1.
- Out  out  ARR x ARR x DATA_WIDTH  result tile; Out[i][j] is row i, column j.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - While reset is high: state=IDLE, read=0, read_addr=0, Out all zero.
- Memory layout (row-major): A[i][k] at base_A + i*K + k; B[k][j] at base_B + k*N + j. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- In IDLE, start=1 does the following:
  - latches base_A, base_B, K and Ne = min(N,8);
  - clears Out to zero on the next edge;
  - enters CLEAR for 1 cycle, then goes to READ with k=0.
- start while not IDLE is ignored.
- K=0: CLEAR goes directly to IDLE and Out stays zero.
- READ issues one read per cycle with read=1:
  - r=0..7: read_addr = base_A + r*K + k; the cycle after each, readdata[0] is captured as a[r].
  - Then nb = ceil(Ne/4) reads (0, 1 or 2) at base_B + k*N + 4*m; the cycle after each, readdata[0..3] are captured as b[4m..4m+3].
  - Captured b[j] with j >= Ne are forced to 0.
- LAST: read=0; captures the final outstanding read's data. Lasts 1 cycle.
- MAC: Out[i][j] <= Out[i][j] + a[i]*b[j] for all i,j. Keeps the low DATA_WIDTH bits of the product and of the sum (wrap, no saturation). Lasts 1 cycle.
- After MAC: if k == K-1, go to IDLE; else k <= k+1 and return to READ.
- Timing: each k-step takes 8+nb+2 cycles. The result is final on entering IDLE; Out then holds until the next start or reset.
- read is 1 only in READ; read_addr holds its last value when read=0.
- Out shows partial sums during operation. Columns j >= Ne stay 0.
- Reset mid-operation aborts immediately and returns to the reset values.

Optional Feature:
- Macro SA_ACCUMULATE_EN.
- Defined: start does not clear Out; each operation adds A x B onto the existing Out (CLEAR cycle still taken). Reset still zeros Out.
- Undefined: Out is cleared at every accepted start, as specified above.

Test Plan:
- Constant memory returning readdata={4,3,2,1} (word0=1) the cycle after read; base_A=10, base_B=70, K=6, N=3; pulse start -> in IDLE, Out[i][0..2]=6,12,18 and Out[i][3..7]=0 for all i.
- Same setup, check the address trace -> k=0 gives 10,16,22,28,34,40,46,52 then 70; k=1 gives 11,17,...,53 then 73; each k-step is 11 cycles (nb=1).
- Real memory: A = 8x8 identity, B = 8x8 with B[k][j]=8k+j, K=N=8 -> Out[i][j]=8i+j; nb=2 with B reads at base_B+8k and base_B+8k+4.
- K=0 pulse start -> read never asserted, Out all zero, back in IDLE after 2 cycles; a second start during busy is ignored (address trace unchanged).
- Reset asserted mid-READ, asynchronously between clock edges -> read=0 and Out=0 immediately; a new start afterwards completes correctly.
- Back-to-back runs with the first scenario -> Out=6,12,18 after both runs without the macro; Out=12,24,36 after the second run with SA_ACCUMULATE_EN.

Source files
------------

// File: rtl/systolic_array_driver.sv
// systolic_array_driver
//   Computes an ARR x ARR tile Out = A x B, one k-step at a time: fetch
//   column k of A (ARR single-word reads) and row k of B (ceil(Ne/READ_BW)
//   wide reads), then outer-product accumulate into ARR*ARR MAC cells.
//
// Ports
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   start                : one-cycle pulse, accepted only when idle
//   base_A, base_B       : word addresses of A[0][0] and B[0][0]
//   dim_col_A, dim_col_B : K (columns of A) and N (columns of B)
//   read, read_addr      : memory read request and word address
//   readdata             : READ_BW words, word w = mem[read_addr+w], one cycle later
//   Out                  : flattened result, Out[i][j] at bits (i*ARR+j)*DATA_WIDTH
//
// Build option
//   SA_ACCUMULATE_EN : when defined, start does not clear Out; each operation
//                      adds A x B onto the existing tile.

module systolic_array_driver #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DIM_WIDTH  = 6,
    parameter int unsigned READ_BW    = 4,
    parameter int unsigned ARR        = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             base_A,
    input  logic [ADDR_WIDTH-1:0]             base_B,
    input  logic [DIM_WIDTH-1:0]              dim_col_A,
    input  logic [DIM_WIDTH-1:0]              dim_col_B,
    output logic                              read,
    output logic [ADDR_WIDTH-1:0]             read_addr,
    input  logic [READ_BW*DATA_WIDTH-1:0]     readdata,
    output logic [ARR*ARR*DATA_WIDTH-1:0]     Out
);

    localparam int unsigned MAX_NB = (ARR + READ_BW - 1) / READ_BW;
    localparam int unsigned CNT_W  = $clog2(ARR + MAX_NB + 1);
    localparam int unsigned NE_W   = $clog2(ARR + 1);
    localparam int unsigned IDX_W  = $clog2(ARR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_LAST,
        S_MAC
    } state_t;

    state_t                  state_q, state_d;
    logic [DIM_WIDTH-1:0]    k_q, k_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    read_d;
    logic [ADDR_WIDTH-1:0]   read_addr_d;

    logic [ADDR_WIDTH-1:0]   base_a_q, base_b_q;
    logic [DIM_WIDTH-1:0]    dim_k_q, dim_n_q;
    logic [NE_W-1:0]         ne_q;
    logic                    cap_valid_q;
    logic [CNT_W-1:0]        cap_idx_q;
    logic [DATA_WIDTH-1:0]   a_q   [ARR];
    logic [DATA_WIDTH-1:0]   b_q   [ARR];
    logic [DATA_WIDTH-1:0]   out_q [ARR][ARR];

    logic                    accept;
    logic [CNT_W-1:0]        nb;
    logic [CNT_W-1:0]        last_cnt;

    assign accept   = (state_q == S_IDLE) && start;
    assign nb       = CNT_W'((32'(ne_q) + READ_BW - 1) / READ_BW);
    assign last_cnt = CNT_W'(ARR) + nb - CNT_W'(1);

    // Address of read slot c in k-step k: slots below ARR walk column k of A,
    // the rest walk row k of B in READ_BW-word chunks. Wraps at ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] addr_for(
        input logic [DIM_WIDTH-1:0]  k,
        input logic [CNT_W-1:0]      c,
        input logic [ADDR_WIDTH-1:0] ba,
        input logic [ADDR_WIDTH-1:0] bb,
        input logic [DIM_WIDTH-1:0]  kd,
        input logic [DIM_WIDTH-1:0]  nd
    );
        logic [ADDR_WIDTH-1:0] addr;
        if (c < CNT_W'(ARR)) begin
            addr = ba + ADDR_WIDTH'(c) * ADDR_WIDTH'(kd) + ADDR_WIDTH'(k);
        end else begin
            addr = bb + ADDR_WIDTH'(k) * ADDR_WIDTH'(nd)
                 + ADDR_WIDTH'(c - CNT_W'(ARR)) * ADDR_WIDTH'(READ_BW);
        end
        return addr;
    endfunction

    // Sequencer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            read      <= 1'b0;
            read_addr <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            read      <= read_d;
            read_addr <= read_addr_d;
        end
    end

    // Next-state and next read request; read is high exactly while in READ
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        read_d      = 1'b0;
        read_addr_d = read_addr;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (dim_k_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_READ;
                    k_d         = '0;
                    cnt_d       = '0;
                    read_d      = 1'b1;
                    read_addr_d = addr_for('0, '0, base_a_q, base_b_q, dim_k_q, dim_n_q);
                end
            end
            S_READ: begin
                if (cnt_q == last_cnt) begin
                    state_d = S_LAST;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    read_d      = 1'b1;
                    read_addr_d = addr_for(k_q, cnt_q + CNT_W'(1), base_a_q, base_b_q,
                                           dim_k_q, dim_n_q);
                end
            end
            S_LAST: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                if (k_q == dim_k_q - DIM_WIDTH'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_READ;
                    k_d         = k_q + DIM_WIDTH'(1);
                    cnt_d       = '0;
                    read_d      = 1'b1;
                    read_addr_d = addr_for(k_q + DIM_WIDTH'(1), '0, base_a_q, base_b_q,
                                           dim_k_q, dim_n_q);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand latch, read-data capture and MAC grid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_a_q    <= '0;
            base_b_q    <= '0;
            dim_k_q     <= '0;
            dim_n_q     <= '0;
            ne_q        <= '0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            for (int i = 0; i < ARR; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                for (int j = 0; j < ARR; j++) out_q[i][j] <= '0;
            end
        end else begin
            // Tag of the read issued this cycle; its data arrives next cycle
            cap_valid_q <= read;
            cap_idx_q   <= cnt_q;

            if (accept) begin
                base_a_q <= base_A;
                base_b_q <= base_B;
                dim_k_q  <= dim_col_A;
                dim_n_q  <= dim_col_B;
                ne_q     <= (dim_col_B > DIM_WIDTH'(ARR)) ? NE_W'(ARR) : NE_W'(dim_col_B);
                // Stale operands must not leak into columns never fetched
                for (int i = 0; i < ARR; i++) begin
                    a_q[i] <= '0;
                    b_q[i] <= '0;
`ifndef SA_ACCUMULATE_EN
                    for (int j = 0; j < ARR; j++) out_q[i][j] <= '0;
`endif
                end
            end else if (cap_valid_q) begin
                if (cap_idx_q < CNT_W'(ARR)) begin
                    a_q[cap_idx_q[IDX_W-1:0]] <= readdata[DATA_WIDTH-1:0];
                end else begin
                    // Columns at or beyond Ne are forced to zero
                    for (int j = 0; j < ARR; j++) begin
                        if (CNT_W'(j / READ_BW) == cap_idx_q - CNT_W'(ARR)) begin
                            b_q[j] <= (NE_W'(j) < ne_q)
                                    ? readdata[(j % READ_BW)*DATA_WIDTH +: DATA_WIDTH]
                                    : '0;
                        end
                    end
                end
            end

            if (state_q == S_MAC) begin
                for (int i = 0; i < ARR; i++) begin
                    for (int j = 0; j < ARR; j++) begin
                        out_q[i][j] <= out_q[i][j] + DATA_WIDTH'(a_q[i] * b_q[j]);
                    end
                end
            end
        end
    end

    // Flatten the tile onto the output bus
    for (genvar gi = 0; gi < ARR; gi++) begin : g_row
        for (genvar gj = 0; gj < ARR; gj++) begin : g_col
            assign Out[(gi*ARR+gj)*DATA_WIDTH +: DATA_WIDTH] = out_q[gi][gj];
        end
    end

endmodule

// File: tb/tb_systolic_array_driver.sv
// Testbench for systolic_array_driver: operand memory model, per-cycle read
// trace checks and an arithmetic reference model of the result tile.

module tb_systolic_array_driver;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 12;
    localparam int unsigned DMW = 6;
    localparam int unsigned RBW = 4;
    localparam int unsigned NA  = 8;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    logic [AW-1:0]         base_A, base_B;
    logic [DMW-1:0]        dim_col_A, dim_col_B;
    logic                  read;
    logic [AW-1:0]         read_addr;
    logic [RBW*DW-1:0]     readdata;
    logic [NA*NA*DW-1:0]   Out;

    systolic_array_driver dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_A    (base_A),
        .base_B    (base_B),
        .dim_col_A (dim_col_A),
        .dim_col_B (dim_col_B),
        .read      (read),
        .read_addr (read_addr),
        .readdata  (readdata),
        .Out       (Out)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [0:4095];
    bit            const_mode;

    // Memory: data for a request appears the cycle after read=1
    always @(posedge clock) begin
        if (read) begin
            for (int w = 0; w < RBW; w++) begin
                readdata[w*DW +: DW] <= const_mode ? DW'(w + 1)
                                                   : mem[AW'(read_addr + AW'(w))];
            end
        end
    end

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] model_out [NA][NA];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] out_at(input int i, input int j);
        return Out[(i*NA+j)*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] a_elem(input logic [AW-1:0] ba, input int kk, input int i,
                                             input int k);
        if (const_mode) return DW'(1);
        return mem[AW'(ba + AW'(i*kk + k))];
    endfunction

    function automatic logic [DW-1:0] b_elem(input logic [AW-1:0] bb, input int nn, input int k,
                                             input int j);
        if (const_mode) return DW'(j % RBW + 1);
        return mem[AW'(bb + AW'(k*nn + j))];
    endfunction

    // Runs one operation starting at the current negedge. inject_c >= 0 pulses a
    // spurious start at that cycle; reset_c >= 0 aborts with reset at that cycle.
    task automatic run_op(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input int kk,
                          input int nn, input int inject_c, input int reset_c);
        int ne, nb, step, total;
        bit            erd   [0:1023];
        logic [AW-1:0] eaddr [0:1023];
        logic [AW-1:0] hold_addr;
        bit            seen_read;
        ne   = (nn > NA) ? NA : nn;
        nb   = (ne + RBW - 1) / RBW;
        step = NA + nb + 2;
        total = 1 + kk * step;
        for (int c = 0; c <= total; c++) begin
            erd[c]   = 1'b0;
            eaddr[c] = '0;
        end
        for (int s = 0; s < kk; s++) begin
            for (int r = 0; r < NA + nb; r++) begin
                erd[1 + s*step + r]   = 1'b1;
                eaddr[1 + s*step + r] = (r < NA) ? AW'(ba + AW'(r*kk + s))
                                                 : AW'(bb + AW'(s*nn + RBW*(r - NA)));
            end
        end
`ifndef SA_ACCUMULATE_EN
        for (int i = 0; i < NA; i++) for (int j = 0; j < NA; j++) model_out[i][j] = '0;
`endif
        for (int k = 0; k < kk; k++)
            for (int i = 0; i < NA; i++)
                for (int j = 0; j < ne; j++)
                    model_out[i][j] = model_out[i][j] + a_elem(ba, kk, i, k) * b_elem(bb, nn, k, j);

        base_A    = ba;
        base_B    = bb;
        dim_col_A = DMW'(kk);
        dim_col_B = DMW'(nn);
        start     = 1'b1;
        seen_read = 1'b0;
        hold_addr = '0;
        for (int c = 0; c <= total; c++) begin
            @(negedge clock);
            start = 1'b0;
            check_eq($sformatf("read c=%0d", c), read, erd[c]);
            if (erd[c]) begin
                check_eq($sformatf("addr c=%0d", c), read_addr, eaddr[c]);
                hold_addr = eaddr[c];
                seen_read = 1'b1;
            end else if (seen_read) begin
                check_eq($sformatf("addr_hold c=%0d", c), read_addr, hold_addr);
            end
            if (c == inject_c) begin
                start     = 1'b1;
                base_A    = AW'($urandom);
                base_B    = AW'($urandom);
                dim_col_A = DMW'($urandom_range(1, 9));
                dim_col_B = DMW'($urandom_range(0, 12));
            end
            if (c == reset_c) begin
                #2 reset = 1'b1;
                #1;
                check_eq("abort_read", read, 1'b0);
                check_eq("abort_addr", read_addr, '0);
                check_eq("abort_out_zero", 64'(|Out), 64'd0);
                @(negedge clock);
                reset = 1'b0;
                for (int i = 0; i < NA; i++) for (int j = 0; j < NA; j++) model_out[i][j] = '0;
                return;
            end
        end
        for (int i = 0; i < NA; i++)
            for (int j = 0; j < NA; j++)
                check_eq($sformatf("out[%0d][%0d]", i, j), out_at(i, j), model_out[i][j]);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        base_A     = '0;
        base_B     = '0;
        dim_col_A  = '0;
        dim_col_B  = '0;
        const_mode = 1'b1;
        for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
        for (int i = 0; i < NA; i++) for (int j = 0; j < NA; j++) model_out[i][j] = '0;

        repeat (2) @(negedge clock);
        check_eq("rst_read", read, 1'b0);
        check_eq("rst_addr", read_addr, '0);
        check_eq("rst_out_zero", 64'(|Out), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Constant memory, with an ignored start while busy
        run_op(12'd10, 12'd70, 6, 3, 5, -1);
        check_eq("const_00", out_at(0, 0), 6);
        check_eq("const_31", out_at(3, 1), 12);
        check_eq("const_72", out_at(7, 2), 18);
        check_eq("const_53", out_at(5, 3), 0);
        check_eq("const_27", out_at(2, 7), 0);
        // Back-to-back run
        run_op(12'd10, 12'd70, 6, 3, -1, -1);
        // K=0, followed immediately by a start two cycles later
        run_op(12'd200, 12'd300, 0, 5, -1, -1);

        // Identity A times counting B, aborted once by reset then rerun
        const_mode = 1'b0;
        for (int i = 0; i < NA; i++)
            for (int k = 0; k < NA; k++) mem[100 + i*NA + k] = (i == k) ? 32'd1 : 32'd0;
        for (int k = 0; k < NA; k++)
            for (int j = 0; j < NA; j++) mem[300 + k*NA + j] = DW'(NA*k + j);
        run_op(12'd100, 12'd300, 8, 8, -1, 1 + 2*12 + 3);
        run_op(12'd100, 12'd300, 8, 8, -1, -1);
        for (int i = 0; i < NA; i++)
            check_eq($sformatf("ident[%0d]", i), out_at(i, (i*3) % NA), DW'(NA*i + (i*3) % NA));

        // Address wrap near the top of memory
        run_op(12'd4090, 12'd4093, 5, 7, -1, -1);

        // Randomized operations
        for (int t = 0; t < 12; t++) begin
            run_op(AW'($urandom), AW'($urandom), $urandom_range(0, 7), $urandom_range(0, 12),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
